fetch_redirect_ctrl: RTL and testbench

//  Sequences all PC redirects into the fetch stage: exception/eret/tlb_op flushes, EX-stage branch

---
 rtl/fetch_redirect_ctrl_pkg.sv | 22 ++
 rtl/fetch_redirect_ctrl_prio_sel.sv | 43 ++++
 rtl/fetch_redirect_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states,
// redirect source encoding and the default boot vector.
package fetch_redirect_ctrl_pkg;

    localparam int          VADDR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        PRED_DS,
        CORR_DS,
        ISSUE
    } redirect_state_t;

    typedef enum logic [1:0] {
        SRC_FLUSH,
        SRC_CORR,
        SRC_PRED
    } redirect_src_t;

endpackage

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// Combinational priority select: flush > correction > prediction.
// Ports: three qualified requests with targets in; winner valid/src/target out.
module fetch_redirect_ctrl_prio_sel
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int VADDR_W = VADDR_W_DEF
) (
    input  logic               flush_req,
    input  logic [VADDR_W-1:0] flush_target,
    input  logic               corr_req,
    input  logic [VADDR_W-1:0] corr_target,
    input  logic               pred_req,
    input  logic [VADDR_W-1:0] pred_target,
    output logic               sel_valid,
    output redirect_src_t      sel_src,
    output logic [VADDR_W-1:0] sel_target
);

    always_comb begin
        sel_valid  = 1'b0;
        sel_src    = SRC_PRED;
        sel_target = pred_target;
        priority case (1'b1)
            flush_req: begin
                sel_valid  = 1'b1;
                sel_src    = SRC_FLUSH;
                sel_target = flush_target;
            end
            corr_req: begin
                sel_valid  = 1'b1;
                sel_src    = SRC_CORR;
                sel_target = corr_target;
            end
            pred_req: begin
                sel_valid  = 1'b1;
                sel_src    = SRC_PRED;
                sel_target = pred_target;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Sequences flush, mispredict-correction and BPU redirects into IF,
// holding branch redirects until the delay slot has been fetched.
// Ports: flush_*/es_*/bpu_* sources, if_fire/redirect_ack from IF;
// registered redirect_valid/redirect_pc/flush_fetch/is_correction out.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int                 VADDR_W  = VADDR_W_DEF,
    parameter logic [VADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_ex,
    input  logic               flush_eret,
    input  logic               flush_tlb,
    input  logic [VADDR_W-1:0] flush_target,
    input  logic               es_verify_valid,
    input  logic               es_mispredict,
    input  logic [VADDR_W-1:0] es_target,
    input  logic               es_ds_fetched,
    input  logic               bpu_pred_valid,
    input  logic               bpu_pred_taken,
    input  logic [VADDR_W-1:0] bpu_pred_target,
    input  logic               if_fire,
    input  logic               redirect_ack,
    output logic               redirect_valid,
    output logic [VADDR_W-1:0] redirect_pc,
    output logic               flush_fetch,
    output logic               is_correction
);

    redirect_state_t    state;
    logic [VADDR_W-1:0] pend_target;

    logic               flush_req;
    logic               corr_req;
    logic               pred_req;
    logic               sel_valid;
    redirect_src_t      sel_src;
    logic [VADDR_W-1:0] sel_target;

    assign flush_req = flush_ex | flush_eret | flush_tlb;

    // Corrections only land while nothing stronger is committed;
    // in CORR_DS the first resolved branch already owns the redirect.
    assign corr_req = es_verify_valid & es_mispredict &
                      ((state == IDLE) | (state == PRED_DS));

    assign pred_req = bpu_pred_valid & bpu_pred_taken &
                      (state == IDLE) & ~is_correction;

    fetch_redirect_ctrl_prio_sel #(
        .VADDR_W (VADDR_W)
    ) u_prio_sel (
        .flush_req    (flush_req),
        .flush_target (flush_target),
        .corr_req     (corr_req),
        .corr_target  (es_target),
        .pred_req     (pred_req),
        .pred_target  (bpu_pred_target),
        .sel_valid    (sel_valid),
        .sel_src      (sel_src),
        .sel_target   (sel_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pend_target    <= '0;
            redirect_valid <= 1'b1;
            redirect_pc    <= RESET_PC;
            flush_fetch    <= 1'b0;
            is_correction  <= 1'b0;
        end else begin
            flush_fetch <= 1'b0;
            if (sel_valid && sel_src == SRC_FLUSH) begin
                state          <= ISSUE;
                redirect_valid <= 1'b1;
                redirect_pc    <= sel_target;
                flush_fetch    <= 1'b1;
                is_correction  <= 1'b0;
            end else begin
                unique case (state)
                    BOOT: begin
                        if (redirect_ack) begin
                            state          <= IDLE;
                            redirect_valid <= 1'b0;
                        end
                    end
                    IDLE, PRED_DS: begin
                        if (sel_valid && sel_src == SRC_CORR) begin
                            is_correction <= 1'b1;
                            if (es_ds_fetched) begin
                                state          <= ISSUE;
                                redirect_valid <= 1'b1;
                                redirect_pc    <= sel_target;
                                flush_fetch    <= 1'b1;
                            end else begin
                                state       <= CORR_DS;
                                pend_target <= sel_target;
                            end
                        end else if (sel_valid && sel_src == SRC_PRED) begin
                            state       <= PRED_DS;
                            pend_target <= sel_target;
                        end else if (state == PRED_DS && if_fire) begin
                            state          <= ISSUE;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= pend_target;
                            flush_fetch    <= 1'b1;
                        end
                    end
                    CORR_DS: begin
                        if (if_fire) begin
                            state          <= ISSUE;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= pend_target;
                            flush_fetch    <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (redirect_ack) begin
                            state          <= IDLE;
                            redirect_valid <= 1'b0;
                            is_correction  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus random
// traffic, each cycle compared against a pending-redirect model.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_ex, flush_eret, flush_tlb;
    logic [31:0] flush_target;
    logic        es_verify_valid, es_mispredict, es_ds_fetched;
    logic [31:0] es_target;
    logic        bpu_pred_valid, bpu_pred_taken;
    logic [31:0] bpu_pred_target;
    logic        if_fire, redirect_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_fetch, is_correction;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .flush_ex        (flush_ex),
        .flush_eret      (flush_eret),
        .flush_tlb       (flush_tlb),
        .flush_target    (flush_target),
        .es_verify_valid (es_verify_valid),
        .es_mispredict   (es_mispredict),
        .es_target       (es_target),
        .es_ds_fetched   (es_ds_fetched),
        .bpu_pred_valid  (bpu_pred_valid),
        .bpu_pred_taken  (bpu_pred_taken),
        .bpu_pred_target (bpu_pred_target),
        .if_fire         (if_fire),
        .redirect_ack    (redirect_ack),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush_fetch     (flush_fetch),
        .is_correction   (is_correction)
    );

    // Model: what the fetch side should see. "waiting" names the
    // delay slot we are waiting for: 0 none, 1 predicted, 2 correction.
    bit          m_boot, m_issue, m_rv, m_ff, m_corr;
    logic [31:0] m_pc, m_held;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit fl, mis;
        fl   = flush_ex | flush_eret | flush_tlb;
        mis  = es_verify_valid & es_mispredict;
        m_ff = 1'b0;
        if (reset) begin
            m_boot = 1; m_issue = 0; m_rv = 1; m_corr = 0;
            m_pc = 32'hbfc0_0000; m_wait = 0; m_held = '0;
        end else if (fl) begin
            m_boot = 0; m_issue = 1; m_rv = 1; m_ff = 1; m_corr = 0;
            m_pc = flush_target; m_wait = 0;
        end else if (m_boot) begin
            if (redirect_ack) begin m_boot = 0; m_rv = 0; end
        end else if (m_issue) begin
            if (redirect_ack) begin m_issue = 0; m_rv = 0; m_corr = 0; end
        end else if (m_wait == 2) begin
            if (if_fire) begin
                m_issue = 1; m_rv = 1; m_ff = 1; m_pc = m_held; m_wait = 0;
            end
        end else if (mis) begin
            m_corr = 1;
            if (es_ds_fetched) begin
                m_issue = 1; m_rv = 1; m_ff = 1; m_pc = es_target; m_wait = 0;
            end else begin
                m_wait = 2; m_held = es_target;
            end
        end else if (m_wait == 1) begin
            if (if_fire) begin
                m_issue = 1; m_rv = 1; m_ff = 1; m_pc = m_held; m_wait = 0;
            end
        end else if (bpu_pred_valid && bpu_pred_taken && !m_corr) begin
            m_wait = 1; m_held = bpu_pred_target;
        end
    endtask

    task automatic quiet();
        reset = 0; flush_ex = 0; flush_eret = 0; flush_tlb = 0;
        flush_target = '0; es_verify_valid = 0; es_mispredict = 0;
        es_target = '0; es_ds_fetched = 0; bpu_pred_valid = 0;
        bpu_pred_taken = 0; bpu_pred_target = '0; if_fire = 0;
        redirect_ack = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("rv", {31'b0, redirect_valid}, {31'b0, m_rv});
        if (m_rv) chk("pc", redirect_pc, m_pc);
        chk("ff", {31'b0, flush_fetch}, {31'b0, m_ff});
        chk("corr", {31'b0, is_correction}, {31'b0, m_corr});
        quiet();
    endtask

    task automatic ack();
        redirect_ack = 1;
        cyc();
    endtask

    initial begin
        quiet();
        // Reset and boot redirect
        reset = 1; cyc();
        reset = 1; cyc();
        chk("boot_pc", redirect_pc, 32'hbfc0_0000);
        chk("boot_ff", {31'b0, flush_fetch}, 32'd0);
        cyc(); cyc();
        chk("boot_hold", {31'b0, redirect_valid}, 32'd1);
        ack();
        chk("boot_idle", {31'b0, redirect_valid}, 32'd0);

        // Mispredict, delay slot already fetched
        es_verify_valid = 1; es_mispredict = 1; es_ds_fetched = 1;
        es_target = 32'h8000_1000; cyc();
        chk("m1_pc", redirect_pc, 32'h8000_1000);
        chk("m1_ff", {31'b0, flush_fetch}, 32'd1);
        cyc();
        chk("m1_ff_once", {31'b0, flush_fetch}, 32'd0);
        chk("m1_corr", {31'b0, is_correction}, 32'd1);
        ack();
        chk("m1_corr_clr", {31'b0, is_correction}, 32'd0);

        // Mispredict, delay slot not yet fetched
        es_verify_valid = 1; es_mispredict = 1; es_target = 32'h8000_2000;
        cyc();
        chk("m2_wait", {31'b0, redirect_valid}, 32'd0);
        cyc(); cyc();
        chk("m2_wait2", {31'b0, redirect_valid}, 32'd0);
        if_fire = 1; cyc();
        chk("m2_pc", redirect_pc, 32'h8000_2000);
        ack();

        // Prediction overridden by mispredict before delay slot
        bpu_pred_valid = 1; bpu_pred_taken = 1;
        bpu_pred_target = 32'h8000_3000; cyc();
        es_verify_valid = 1; es_mispredict = 1; es_target = 32'h8000_5000;
        cyc();
        if_fire = 1; cyc();
        chk("m3_pc", redirect_pc, 32'h8000_5000);
        ack();

        // Flush during CORR_DS drops the correction
        es_verify_valid = 1; es_mispredict = 1; es_target = 32'h8000_6000;
        cyc();
        flush_ex = 1; flush_target = 32'hbfc0_0380; cyc();
        chk("m4_pc", redirect_pc, 32'hbfc0_0380);
        chk("m4_corr", {31'b0, is_correction}, 32'd0);
        if_fire = 1; cyc();
        chk("m4_keep", redirect_pc, 32'hbfc0_0380);
        ack();

        // Ack and flush together in ISSUE
        es_verify_valid = 1; es_mispredict = 1; es_ds_fetched = 1;
        es_target = 32'h8000_7000; cyc();
        cyc();
        redirect_ack = 1; flush_eret = 1; flush_target = 32'h8000_4000;
        cyc();
        chk("m5_pc", redirect_pc, 32'h8000_4000);
        chk("m5_ff", {31'b0, flush_fetch}, 32'd1);
        ack();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(0, 199) == 0);
            flush_ex        = ($urandom_range(0, 39) == 0);
            flush_eret      = ($urandom_range(0, 59) == 0);
            flush_tlb       = ($urandom_range(0, 59) == 0);
            flush_target    = $urandom;
            es_verify_valid = ($urandom_range(0, 3) == 0);
            es_mispredict   = $urandom_range(0, 1) == 1;
            es_ds_fetched   = $urandom_range(0, 1) == 1;
            es_target       = $urandom;
            bpu_pred_valid  = $urandom_range(0, 1) == 1;
            bpu_pred_taken  = $urandom_range(0, 1) == 1;
            bpu_pred_target = $urandom;
            if_fire         = $urandom_range(0, 2) == 0;
            redirect_ack    = m_rv ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
